// File: rtl/ahb_sel_decoder.sv
// AHB subordinate select decoder with a data-phase response mux and a default subordinate.
// Define AHB_SEL_DECODER_ERR_CNT_EN to add the saturating ERR_CNT output.
module ahb_sel_decoder #(
    parameter int ADDR_WIDTH            = 32,
    parameter int DATA_WIDTH            = 32,
    parameter int NO_OF_SUBORDINATES    = 3,
    parameter int BITS_FOR_SUBORDINATES = $clog2(NO_OF_SUBORDINATES + 1)
) (
    input  logic                                     HCLK,
    input  logic                                     HRESET,
    input  logic [ADDR_WIDTH-1:0]                    HADDR,
    input  logic [1:0]                               HTRANS,
    input  logic [NO_OF_SUBORDINATES-1:0]            HREADYOUT_S,
    input  logic [NO_OF_SUBORDINATES-1:0]            HRESP_S,
    input  logic [NO_OF_SUBORDINATES*DATA_WIDTH-1:0] HRDATA_S,
    output logic [NO_OF_SUBORDINATES-1:0]            HSEL,
    output logic                                     HREADY,
    output logic                                     HRESP,
    output logic [DATA_WIDTH-1:0]                    HRDATA
`ifdef AHB_SEL_DECODER_ERR_CNT_EN
    ,
    output logic [15:0]                              ERR_CNT
`endif
);

    localparam int N  = NO_OF_SUBORDINATES;
    localparam int RW = BITS_FOR_SUBORDINATES;
    localparam logic [RW-1:0] N_SUB = RW'(N);

    // ST_IDLE: zero-wait OKAY | ST_ERR1: wait + ERROR | ST_ERR2: ready + ERROR
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            dflt_ready_q, dflt_ready_d;
    logic            dflt_resp_q, dflt_resp_d;
    logic            active_q, active_d;
    logic [RW-1:0]   region_q, region_d;

    logic [RW-1:0]         addr_region;
    logic                  addr_is_dflt;
    logic                  err_req;
    logic                  hready_m;
    logic                  hresp_m;
    logic [DATA_WIDTH-1:0] hrdata_m;
    logic                  unused_inputs;

    assign addr_region   = HADDR[ADDR_WIDTH-1 -: RW];
    assign addr_is_dflt  = (addr_region >= N_SUB);
    assign unused_inputs = ^{HTRANS[0], HADDR[ADDR_WIDTH-RW-1:0]};

    always_comb begin
        HSEL = '0;
        for (int k = 0; k < N; k++) begin
            HSEL[k] = (addr_region == RW'(k));
        end
    end

    // Data phase belongs to whoever was addressed when HREADY last completed a cycle.
    always_comb begin
        hready_m = dflt_ready_q;
        hresp_m  = dflt_resp_q;
        hrdata_m = '0;
        for (int k = 0; k < N; k++) begin
            if (active_q && (region_q == RW'(k))) begin
                hready_m = HREADYOUT_S[k];
                hresp_m  = HRESP_S[k];
                hrdata_m = HRDATA_S[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign HREADY = hready_m;
    assign HRESP  = hresp_m;
    assign HRDATA = hrdata_m;

    assign err_req = hready_m && HTRANS[1] && addr_is_dflt;

    always_comb begin
        region_d = region_q;
        active_d = active_q;
        if (hready_m) begin
            region_d = addr_region;
            active_d = HTRANS[1];
        end

        state_d = state_q;
        case (state_q)
            ST_IDLE: if (err_req) state_d = ST_ERR1;
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = err_req ? ST_ERR1 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        dflt_ready_d = (state_d != ST_ERR1);
        dflt_resp_d  = (state_d != ST_IDLE);
    end

`ifdef AHB_SEL_DECODER_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_req && (state_q != ST_ERR1) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign ERR_CNT = err_cnt_q;
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q      <= ST_IDLE;
            dflt_ready_q <= 1'b1;
            dflt_resp_q  <= 1'b0;
            active_q     <= 1'b0;
            region_q     <= '0;
        end else begin
            state_q      <= state_d;
            dflt_ready_q <= dflt_ready_d;
            dflt_resp_q  <= dflt_resp_d;
            active_q     <= active_d;
            region_q     <= region_d;
        end
    end

endmodule

// File: tb/tb_ahb_sel_decoder.sv
// Randomized scoreboard bench for ahb_sel_decoder (N=3) with directed AHB scenarios.
module tb_ahb_sel_decoder;

    localparam int N = 3;
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10, T_SEQ = 2'b11;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HREADYOUT_S, HRESP_S;
    logic [95:0] HRDATA_S;
    logic [2:0]  HSEL;
    logic        HREADY, HRESP;
    logic [31:0] HRDATA;
`ifdef AHB_SEL_DECODER_ERR_CNT_EN
    logic [15:0] ERR_CNT;
`endif

    ahb_sel_decoder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NO_OF_SUBORDINATES(3), .BITS_FOR_SUBORDINATES(2)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
        .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S), .HRDATA_S(HRDATA_S),
        .HSEL(HSEL), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
`ifdef AHB_SEL_DECODER_ERR_CNT_EN
        , .ERR_CNT(ERR_CNT)
`endif
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [2:0]  hsel;
        logic        hready;
        logic        hresp;
        logic [31:0] hrdata;
        logic [15:0] errcnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: who owns the data phase, plus the scripted default-subordinate
    // response sequence ({ready,resp} per cycle) queued by each accepted error transfer.
    bit       m_valid  = 0;
    bit       m_active = 0;
    int       m_owner  = 0;
    int       m_errcnt = 0;
    bit [1:0] m_script[$];

    function automatic exp_t model_out(input logic [31:0] addr, input logic [2:0] rdy,
                                       input logic [2:0] resp, input logic [95:0] data);
        exp_t e;
        int   r;
        r = int'(addr[31:30]);
        e.hsel = (r < N) ? 3'(1 << r) : 3'b000;
        if (m_active && m_owner < N) begin
            e.hready = rdy[m_owner];
            e.hresp  = resp[m_owner];
            e.hrdata = data[m_owner*32 +: 32];
        end else begin
            e.hrdata = 32'h0;
            if (m_script.size() == 0) begin
                e.hready = 1'b1;
                e.hresp  = 1'b0;
            end else begin
                e.hready = m_script[0][1];
                e.hresp  = m_script[0][0];
            end
        end
        e.errcnt = (m_errcnt > 65535) ? 16'hFFFF : 16'(m_errcnt);
        return e;
    endfunction

    task automatic cycle(input logic [31:0] addr, input logic [1:0] trans, input logic [2:0] rdy,
                         input logic [2:0] resp, input logic [95:0] data, input logic rst);
        exp_t e;
        HADDR = addr; HTRANS = trans; HREADYOUT_S = rdy; HRESP_S = resp;
        HRDATA_S = data; HRESET = rst;
        e = model_out(addr, rdy, resp, data);
        if (m_valid) sb_q.push_back(e);
        @(posedge HCLK);
        if (rst) begin
            m_valid = 1; m_active = 0; m_owner = 0; m_errcnt = 0;
            m_script.delete();
        end else if (m_valid) begin
            if (m_script.size() > 0) void'(m_script.pop_front());
            if (e.hready && trans[1] && int'(addr[31:30]) >= N) begin
                m_script.push_back(2'b01);
                m_script.push_back(2'b11);
                m_errcnt++;
            end
            if (e.hready) begin
                m_active = trans[1];
                m_owner  = int'(addr[31:30]);
            end
        end
        #1;
    endtask

    function automatic logic [95:0] rnd_data();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    task automatic go(input logic [31:0] addr, input logic [1:0] trans);
        cycle(addr, trans, 3'b111, 3'b000, rnd_data(), 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    exp_t me;
    always @(negedge HCLK) begin
        if (sb_q.size() > 0) begin
            me = sb_q.pop_front();
            chk("hsel",   32'(HSEL),   32'(me.hsel));
            chk("hready", 32'(HREADY), 32'(me.hready));
            chk("hresp",  32'(HRESP),  32'(me.hresp));
            chk("hrdata", HRDATA,      me.hrdata);
`ifdef AHB_SEL_DECODER_ERR_CNT_EN
            chk("err_cnt", 32'(ERR_CNT), 32'(me.errcnt));
`endif
        end
    end

    initial begin
        logic [95:0] d;
        logic [2:0]  rdy;
        logic [2:0]  rsp;
        HRESET = 1'b1; HADDR = '0; HTRANS = T_IDLE;
        HREADYOUT_S = 3'b111; HRESP_S = '0; HRDATA_S = '0;
        @(posedge HCLK); #1;
        cycle(32'h0, T_IDLE, 3'b111, 3'b000, rnd_data(), 1'b1);
        cycle(32'h0, T_IDLE, 3'b111, 3'b000, rnd_data(), 1'b1);

        // wait-stated read from subordinate 1
        d = rnd_data(); d[63:32] = 32'hDEAD_BEEF;
        cycle(32'h4000_0000, T_NS,   3'b111, 3'b000, d, 1'b0);
        cycle(32'h0000_0000, T_IDLE, 3'b101, 3'b000, d, 1'b0);
        cycle(32'h0000_0000, T_IDLE, 3'b101, 3'b000, d, 1'b0);
        cycle(32'h0000_0000, T_IDLE, 3'b111, 3'b000, d, 1'b0);

        // default region error, then IDLE/BUSY to default region
        go(32'hC000_0000, T_NS);
        repeat (3) go(32'h0, T_IDLE);
        repeat (3) go(32'hC000_0000, T_IDLE);
        go(32'hC000_0000, T_BUSY);
        go(32'hC000_1234, T_SEQ);
        repeat (3) go(32'h0, T_IDLE);

        // subordinate 0 stalls while next address targets subordinate 2
        d = rnd_data();
        cycle(32'h0000_0010, T_NS, 3'b111, 3'b000, d, 1'b0);
        cycle(32'h8000_0000, T_NS, 3'b110, 3'b000, d, 1'b0);
        cycle(32'h8000_0000, T_NS, 3'b110, 3'b000, d, 1'b0);
        cycle(32'h8000_0000, T_NS, 3'b111, 3'b001, d, 1'b0);
        go(32'h0, T_IDLE);
        go(32'h0, T_IDLE);

        // reset while in the first error cycle
        go(32'hC000_0000, T_NS);
        cycle(32'h0, T_IDLE, 3'b111, 3'b000, rnd_data(), 1'b1);
        repeat (2) go(32'h0, T_IDLE);

        // three back-to-back error transfers
        cycle(32'h0, T_IDLE, 3'b111, 3'b000, rnd_data(), 1'b1);
        repeat (5) go(32'hC000_0000, T_NS);
        repeat (3) go(32'h0, T_IDLE);

        for (int i = 0; i < 800; i++) begin
            for (int b = 0; b < 3; b++) begin
                rdy[b] = ($urandom_range(3) != 0);
                rsp[b] = ($urandom_range(7) == 0);
            end
            cycle($urandom(), 2'($urandom_range(3)), rdy, rsp, rnd_data(),
                  ($urandom_range(49) == 0));
        end
        go(32'h0, T_IDLE);

        for (int w = 0; w < 5 && sb_q.size() > 0; w++) @(negedge HCLK);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
